reg_file_sequencer: RTL and testbench

Burst command sequencer sitting directly upstream of the 8-entry register file. It accepts read/write burst commands over a valid/ready interface and streams write data in and read data out with handshakes. It generates the register file's single-cycle write/read enables, address and write data, and never asserts both enables together. Bursts run 1–8 beats with the address auto-incrementing modulo 8.

---
 rtl/reg_file_seq_pkg.sv | 14 +
 rtl/rf_burst_counter.sv | 48 ++++
 rtl/reg_file_sequencer.sv | 130 +++++++++++++
 tb/tb_reg_file_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_seq_pkg.sv
// Shared types and constants for the register-file burst sequencer.
package reg_file_seq_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int LEN_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_REQ  = 2'd2,
    RD_DATA = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rf_burst_counter.sv
// Burst position tracker: wrapping address incrementer plus remaining-beat down-counter.
module rf_burst_counter
  import reg_file_seq_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;

  // The address wraps naturally at the width of the 8-entry file.
  assign next_addr_o = addr_q + 1'b1;
  assign addr_o      = addr_q;
  assign last_o      = (beats_q == '0);

  always_comb begin
    addr_d  = addr_q;
    beats_d = beats_q;
    if (load_i) begin
      addr_d  = addr_i;
      beats_d = len_i;
    end else if (step_i) begin
      addr_d = next_addr_o;
      if (beats_q != '0) begin
        beats_d = beats_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: rtl/reg_file_sequencer.sv
// Burst command sequencer driving the single-cycle enables of an 8-entry register file.
module reg_file_sequencer
  import reg_file_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic                  Cmd_Write,
  input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
  input  logic [LEN_WIDTH-1:0]  Cmd_Len,
  input  logic                  Wd_Valid,
  output logic                  Wd_Ready,
  input  logic [DATA_WIDTH-1:0] Wd_Data,
  output logic                  Rd_Valid,
  input  logic                  Rd_Ready,
  output logic [DATA_WIDTH-1:0] Rd_Data,
  output logic                  Rd_Last,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  output logic                  Busy
);

  seq_state_e            state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  cnt_load, cnt_step, cnt_last;
  logic [ADDR_WIDTH-1:0] cur_addr, next_addr;

  rf_burst_counter u_counter (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (cnt_load),
    .step_i      (cnt_step),
    .addr_i      (Cmd_Addr),
    .len_i       (Cmd_Len),
    .addr_o      (cur_addr),
    .next_addr_o (next_addr),
    .last_o      (cnt_last)
  );

  assign Cmd_Ready  = (state_q == IDLE);
  assign Wd_Ready   = (state_q == WR);
  assign Rd_Valid   = (state_q == RD_DATA);
  assign Rd_Last    = (state_q == RD_DATA) && cnt_last;
  assign Rd_Data    = RF_RdData;
  assign Busy       = (state_q != IDLE);
  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;

  // Read enables are only ever raised on entry to RD_REQ and write enables only
  // from a WR beat, so the two can never coincide.
  always_comb begin
    state_d  = state_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Cmd_Valid) begin
          cnt_load = 1'b1;
          if (Cmd_Write) begin
            state_d = WR;
          end else begin
            state_d = RD_REQ;
            rd_en_d = 1'b1;
            addr_d  = Cmd_Addr;
          end
        end
      end
      WR: begin
        if (Wd_Valid) begin
          wr_en_d  = 1'b1;
          wdata_d  = Wd_Data;
          addr_d   = cur_addr;
          cnt_step = 1'b1;
          if (cnt_last) begin
            state_d = IDLE;
          end
        end
      end
      RD_REQ: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (Rd_Ready) begin
          if (cnt_last) begin
            state_d = IDLE;
          end else begin
            cnt_step = 1'b1;
            addr_d   = next_addr;
            rd_en_d  = 1'b1;
            state_d  = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed self-checking bench for reg_file_sequencer with a behavioural 8-entry register file.
module tb_reg_file_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Write;
  logic [2:0]  Cmd_Addr, Cmd_Len;
  logic        Wd_Valid, Wd_Ready;
  logic [15:0] Wd_Data;
  logic        Rd_Valid, Rd_Ready, Rd_Last;
  logic [15:0] Rd_Data;
  logic        RF_WrEn, RF_RdEn;
  logic [2:0]  RF_Address;
  logic [15:0] RF_WrData, RF_RdData;
  logic        Busy;

  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;
  int wrEnCount = 0;
  int rdEnCount = 0;
  int overlapCount = 0;

  logic [15:0] mem [8];

  reg_file_sequencer #(.DATA_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
    .Wd_Valid(Wd_Valid), .Wd_Ready(Wd_Ready), .Wd_Data(Wd_Data),
    .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Register file: stores on WrEn, refreshes read data on RdEn, never reset.
  always @(posedge CLK) begin
    if (RF_WrEn) mem[RF_Address] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= mem[RF_Address];
  end

  always @(negedge CLK) begin
    if (RF_WrEn) wrEnCount++;
    if (RF_RdEn) rdEnCount++;
    if (RF_WrEn && RF_RdEn) overlapCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sendCmd(input logic wr, input logic [2:0] addr, input logic [2:0] len);
    int n = 0;
    Cmd_Valid = 1'b1; Cmd_Write = wr; Cmd_Addr = addr; Cmd_Len = len;
    while (!Cmd_Ready && n < 16) begin
      tick();
      n++;
    end
    if (n >= 16) begin
      checkCount++; failCount++;
      $display("[TB] FAIL cmd_timeout: Cmd_Ready got %b required 1", Cmd_Ready);
    end
    tick();
    Cmd_Valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; Cmd_Valid = 1'b1; Cmd_Write = 1'b1; Cmd_Addr = 3'd5; Cmd_Len = 3'd2;
    tick(); tick();
    checkCount++;
    if ({Cmd_Ready, Wd_Ready, Rd_Valid, Rd_Last, RF_WrEn, RF_RdEn, Busy} !== 7'b1000000) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %b required 1000000",
               {Cmd_Ready, Wd_Ready, Rd_Valid, Rd_Last, RF_WrEn, RF_RdEn, Busy});
    end else passCount++;
    checkCount++;
    if ({RF_Address, RF_WrData} !== 19'd0) begin
      failCount++;
      $display("[TB] FAIL reset_regs: addr %h wdata %h required 0", RF_Address, RF_WrData);
    end else passCount++;
    RST = 1'b0; Cmd_Valid = 1'b0;
    tick();
    checkCount++;
    if (Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_cmd_discard: Busy got %b required 0", Busy);
    end else passCount++;
  endtask

  task automatic test_single();
    sendCmd(1'b1, 3'd3, 3'd0);
    checkCount++;
    if (Wd_Ready !== 1'b1 || Busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL single_wr_state: Wd_Ready %b Busy %b required 1 1", Wd_Ready, Busy);
    end else passCount++;
    Wd_Valid = 1'b1; Wd_Data = 16'hA5A5;
    tick();
    Wd_Valid = 1'b0;
    checkCount++;
    if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, Cmd_Ready} !== {2'b10, 3'd3, 16'hA5A5, 1'b1}) begin
      failCount++;
      $display("[TB] FAIL single_wr_pulse: WrEn %b RdEn %b addr %h data %h Cmd_Ready %b required 1 0 3 a5a5 1",
               RF_WrEn, RF_RdEn, RF_Address, RF_WrData, Cmd_Ready);
    end else passCount++;
    tick();
    checkCount++;
    if (RF_WrEn !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL single_wr_one_cycle: WrEn got %b required 0", RF_WrEn);
    end else passCount++;
    sendCmd(1'b0, 3'd3, 3'd0);
    checkCount++;
    if ({RF_RdEn, RF_Address, Rd_Valid} !== {1'b1, 3'd3, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_rd_req: RdEn %b addr %h Rd_Valid %b required 1 3 0", RF_RdEn, RF_Address, Rd_Valid);
    end else passCount++;
    tick();
    checkCount++;
    if ({Rd_Valid, Rd_Data, Rd_Last, RF_RdEn} !== {1'b1, 16'hA5A5, 1'b1, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_rd_data: valid %b data %h last %b RdEn %b required 1 a5a5 1 0",
               Rd_Valid, Rd_Data, Rd_Last, RF_RdEn);
    end else passCount++;
    Rd_Ready = 1'b1;
    tick();
    Rd_Ready = 1'b0;
    checkCount++;
    if ({Rd_Valid, Cmd_Ready, Busy} !== 3'b010) begin
      failCount++;
      $display("[TB] FAIL single_rd_done: valid %b Cmd_Ready %b Busy %b required 0 1 0", Rd_Valid, Cmd_Ready, Busy);
    end else passCount++;
  endtask

  task automatic test_wrap_burst();
    logic [15:0] wd [4];
    logic [2:0]  wa [4];
    wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wa = '{3'd6, 3'd7, 3'd0, 3'd1};
    sendCmd(1'b1, 3'd6, 3'd3);
    Wd_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Wd_Data = wd[i];
      tick();
      checkCount++;
      if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, wa[i], wd[i]}) begin
        failCount++;
        $display("[TB] FAIL wrap_wr_beat%0d: WrEn %b addr %h data %h required 1 %h %h",
                 i, RF_WrEn, RF_Address, RF_WrData, wa[i], wd[i]);
      end else passCount++;
    end
    Wd_Valid = 1'b0;
    checkCount++;
    if ({Cmd_Ready, Busy} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL wrap_wr_done: Cmd_Ready %b Busy %b required 1 0", Cmd_Ready, Busy);
    end else passCount++;
    tick();
    sendCmd(1'b0, 3'd6, 3'd3);
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if ({RF_RdEn, RF_Address} !== {1'b1, wa[i]}) begin
        failCount++;
        $display("[TB] FAIL wrap_rd_req%0d: RdEn %b addr %h required 1 %h", i, RF_RdEn, RF_Address, wa[i]);
      end else passCount++;
      tick();
      checkCount++;
      if ({Rd_Valid, Rd_Data, Rd_Last} !== {1'b1, wd[i], (i == 3)}) begin
        failCount++;
        $display("[TB] FAIL wrap_rd_beat%0d: valid %b data %h last %b required 1 %h %b",
                 i, Rd_Valid, Rd_Data, Rd_Last, wd[i], (i == 3));
      end else passCount++;
      Rd_Ready = 1'b1;
      tick();
      Rd_Ready = 1'b0;
    end
    checkCount++;
    if (Cmd_Ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL wrap_rd_done: Cmd_Ready got %b required 1", Cmd_Ready);
    end else passCount++;
  endtask

  task automatic test_read_stall();
    logic [15:0] exp [8];
    int rdBefore;
    exp = '{16'h3333, 16'h4444, 16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 16'h1111, 16'h2222};
    rdBefore = rdEnCount;
    sendCmd(1'b0, 3'd0, 3'd7);
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if ({RF_RdEn, RF_Address} !== {1'b1, 3'(i)}) begin
        failCount++;
        $display("[TB] FAIL stall_rd_req%0d: RdEn %b addr %h required 1 %h", i, RF_RdEn, RF_Address, 3'(i));
      end else passCount++;
      tick();
      if (i == 2) begin
        for (int s = 0; s < 3; s++) begin
          checkCount++;
          if ({Rd_Valid, Rd_Data, Rd_Last, RF_RdEn} !== {1'b1, exp[2], 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL stall_hold%0d: valid %b data %h last %b RdEn %b required 1 %h 0 0",
                     s, Rd_Valid, Rd_Data, Rd_Last, RF_RdEn, exp[2]);
          end else passCount++;
          tick();
        end
      end
      checkCount++;
      if ({Rd_Valid, Rd_Data, Rd_Last} !== {1'b1, exp[i], (i == 7)}) begin
        failCount++;
        $display("[TB] FAIL stall_rd_beat%0d: valid %b data %h last %b required 1 %h %b",
                 i, Rd_Valid, Rd_Data, Rd_Last, exp[i], (i == 7));
      end else passCount++;
      Rd_Ready = 1'b1;
      tick();
      Rd_Ready = 1'b0;
    end
    checkCount++;
    if (rdEnCount - rdBefore !== 8) begin
      failCount++;
      $display("[TB] FAIL stall_rden_pulses: got %0d required 8", rdEnCount - rdBefore);
    end else passCount++;
  endtask

  task automatic test_back_to_back();
    int wrBefore;
    Wd_Valid = 1'b1; Wd_Data = 16'hDEAD;
    Rd_Ready = 1'b1;
    tick();
    Rd_Ready = 1'b0;
    checkCount++;
    if ({RF_WrEn, Busy} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL idle_wd_ignored: WrEn %b Busy %b required 0 0", RF_WrEn, Busy);
    end else passCount++;
    Wd_Valid = 1'b0;
    wrBefore = wrEnCount;
    sendCmd(1'b1, 3'd4, 3'd2);
    Wd_Valid = 1'b1; Wd_Data = 16'hBEE0;
    tick();
    checkCount++;
    if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 3'd4, 16'hBEE0}) begin
      failCount++;
      $display("[TB] FAIL gap_beat0: WrEn %b addr %h data %h required 1 4 bee0", RF_WrEn, RF_Address, RF_WrData);
    end else passCount++;
    Wd_Valid = 1'b0; Wd_Data = 16'hDEAD;
    tick(); tick();
    checkCount++;
    if ({RF_WrEn, Wd_Ready} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL gap_idle: WrEn %b Wd_Ready %b required 0 1", RF_WrEn, Wd_Ready);
    end else passCount++;
    Wd_Valid = 1'b1; Wd_Data = 16'hBEE1;
    tick();
    checkCount++;
    if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 3'd5, 16'hBEE1}) begin
      failCount++;
      $display("[TB] FAIL gap_beat1: WrEn %b addr %h data %h required 1 5 bee1", RF_WrEn, RF_Address, RF_WrData);
    end else passCount++;
    Wd_Valid = 1'b0;
    tick();
    Wd_Valid = 1'b1; Wd_Data = 16'hBEE2;
    tick();
    Wd_Valid = 1'b0;
    checkCount++;
    if ({RF_WrEn, RF_Address, RF_WrData, Cmd_Ready} !== {1'b1, 3'd6, 16'hBEE2, 1'b1}) begin
      failCount++;
      $display("[TB] FAIL gap_beat2: WrEn %b addr %h data %h Cmd_Ready %b required 1 6 bee2 1",
               RF_WrEn, RF_Address, RF_WrData, Cmd_Ready);
    end else passCount++;
    Cmd_Valid = 1'b1; Cmd_Write = 1'b0; Cmd_Addr = 3'd6; Cmd_Len = 3'd0;
    tick();
    Cmd_Valid = 1'b0;
    checkCount++;
    if ({RF_RdEn, RF_WrEn, RF_Address} !== {2'b10, 3'd6}) begin
      failCount++;
      $display("[TB] FAIL raw_rd_req: RdEn %b WrEn %b addr %h required 1 0 6", RF_RdEn, RF_WrEn, RF_Address);
    end else passCount++;
    tick();
    checkCount++;
    if ({Rd_Valid, Rd_Data, Rd_Last} !== {1'b1, 16'hBEE2, 1'b1}) begin
      failCount++;
      $display("[TB] FAIL raw_rd_data: valid %b data %h last %b required 1 bee2 1", Rd_Valid, Rd_Data, Rd_Last);
    end else passCount++;
    Rd_Ready = 1'b1;
    tick();
    Rd_Ready = 1'b0;
    checkCount++;
    if (wrEnCount - wrBefore !== 3) begin
      failCount++;
      $display("[TB] FAIL gap_wren_pulses: got %0d required 3", wrEnCount - wrBefore);
    end else passCount++;
  endtask

  task automatic test_reset_mid_burst();
    int wrBefore;
    wrBefore = wrEnCount;
    sendCmd(1'b1, 3'd2, 3'd5);
    Wd_Valid = 1'b1; Wd_Data = 16'h5550;
    tick();
    Wd_Data = 16'h5551;
    tick();
    Wd_Data = 16'h5552;
    RST = 1'b1;
    tick();
    checkCount++;
    if ({Cmd_Ready, Wd_Ready, Rd_Valid, Rd_Last, RF_WrEn, RF_RdEn, Busy, RF_Address, RF_WrData}
        !== {7'b1000000, 3'd0, 16'h0000}) begin
      failCount++;
      $display("[TB] FAIL midrst_outputs: flags %b addr %h data %h required 1000000 0 0",
               {Cmd_Ready, Wd_Ready, Rd_Valid, Rd_Last, RF_WrEn, RF_RdEn, Busy}, RF_Address, RF_WrData);
    end else passCount++;
    RST = 1'b0;
    tick(); tick(); tick();
    Wd_Valid = 1'b0;
    checkCount++;
    if ({wrEnCount - wrBefore, Busy} !== {32'd2, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL midrst_abandon: pulses %0d Busy %b required 2 0", wrEnCount - wrBefore, Busy);
    end else passCount++;
    sendCmd(1'b0, 3'd4, 3'd0);
    tick();
    checkCount++;
    if ({Rd_Valid, Rd_Data} !== {1'b1, 16'hBEE0}) begin
      failCount++;
      $display("[TB] FAIL midrst_untouched: valid %b data %h required 1 bee0", Rd_Valid, Rd_Data);
    end else passCount++;
    Rd_Ready = 1'b1;
    tick();
    Rd_Ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    RF_RdData = 16'h0000;
    RST = 1'b1; Cmd_Valid = 1'b0; Cmd_Write = 1'b0; Cmd_Addr = 3'd0; Cmd_Len = 3'd0;
    Wd_Valid = 1'b0; Wd_Data = 16'h0000; Rd_Ready = 1'b0;
    test_reset();
    test_single();
    test_wrap_burst();
    test_read_stall();
    test_back_to_back();
    test_reset_mid_burst();
    checkCount++;
    if (overlapCount !== 0) begin
      failCount++;
      $display("[TB] FAIL enable_overlap: got %0d cycles required 0", overlapCount);
    end else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
